// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: opcodes, functs,
// control-field codes, FSM states and the decoded instruction record.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_NOP = 6'b000000;

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;
    localparam logic [3:0] ALU_LUI = 4'd6;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    localparam logic [1:0] GPR_RD = 2'b00;
    localparam logic [1:0] GPR_RT = 2'b01;
    localparam logic [1:0] GPR_RA = 2'b10;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_WORD = 2'b01;
    localparam logic [1:0] MW_BYTE = 2'b10;

    localparam logic [2:0] LA_WORD  = 3'b000;
    localparam logic [2:0] LA_SBYTE = 3'b001;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_ILLEGAL = 4'd0,
        C_RALU    = 4'd1,
        C_IALU    = 4'd2,
        C_LOAD    = 4'd3,
        C_STORE   = 4'd4,
        C_BEQ     = 4'd5,
        C_BNE     = 4'd6,
        C_J       = 4'd7,
        C_JAL     = 4'd8,
        C_JR      = 4'd9,
        C_NOP     = 4'd10
    } iclass_t;

    // Static per-instruction fields; the sequencer decides in which state each is driven.
    typedef struct packed {
        iclass_t    cls;
        logic [3:0] alu_op;
        logic       ext_op;
        logic       alu_src;
        logic [1:0] gpr_sel;
        logic [1:0] wd_sel;
        logic [2:0] laddr;
        logic [1:0] mem_write;
    } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: Op/Funct to instruction class plus the
// static datapath fields the sequencer gates per state.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        dec           = '0;
        dec.cls       = C_ILLEGAL;
        dec.alu_op    = ALU_NOP;
        dec.gpr_sel   = GPR_RD;
        dec.wd_sel    = WD_ALU;
        dec.laddr     = LA_WORD;
        dec.mem_write = MW_NONE;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin dec.cls = C_RALU; dec.alu_op = ALU_ADD; end
                    FN_SUB: begin dec.cls = C_RALU; dec.alu_op = ALU_SUB; end
                    FN_AND: begin dec.cls = C_RALU; dec.alu_op = ALU_AND; end
                    FN_OR:  begin dec.cls = C_RALU; dec.alu_op = ALU_OR;  end
                    FN_SLT: begin dec.cls = C_RALU; dec.alu_op = ALU_SLT; end
                    FN_JR:  dec.cls = C_JR;
                    FN_NOP: dec.cls = C_NOP;
                    default: dec.cls = C_ILLEGAL;
                endcase
            end
            OP_ADDI: begin
                dec.cls = C_IALU; dec.alu_op = ALU_ADD; dec.ext_op = 1'b1;
                dec.alu_src = 1'b1; dec.gpr_sel = GPR_RT;
            end
            OP_ORI: begin
                dec.cls = C_IALU; dec.alu_op = ALU_OR;
                dec.alu_src = 1'b1; dec.gpr_sel = GPR_RT;
            end
            OP_LUI: begin
                dec.cls = C_IALU; dec.alu_op = ALU_LUI;
                dec.alu_src = 1'b1; dec.gpr_sel = GPR_RT;
            end
            OP_LW, OP_LB: begin
                dec.cls = C_LOAD; dec.alu_op = ALU_ADD; dec.ext_op = 1'b1;
                dec.alu_src = 1'b1; dec.gpr_sel = GPR_RT; dec.wd_sel = WD_MEM;
                dec.laddr = (op == OP_LB) ? LA_SBYTE : LA_WORD;
            end
            OP_SW, OP_SB: begin
                dec.cls = C_STORE; dec.alu_op = ALU_ADD; dec.ext_op = 1'b1;
                dec.alu_src = 1'b1;
                dec.mem_write = (op == OP_SB) ? MW_BYTE : MW_WORD;
            end
            OP_BEQ: begin dec.cls = C_BEQ; dec.alu_op = ALU_SUB; dec.ext_op = 1'b1; end
            OP_BNE: begin dec.cls = C_BNE; dec.alu_op = ALU_SUB; dec.ext_op = 1'b1; end
            OP_J:   dec.cls = C_J;
            OP_JAL: begin dec.cls = C_JAL; dec.gpr_sel = GPR_RA; dec.wd_sel = WD_PC4; end
            default: dec.cls = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB state register
// with per-state gating of the decoded control fields. en is sampled in FETCH only.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] MemWrite,
    output logic       EXTOp,
    output logic [3:0] ALUOp,
    output logic [1:0] NPCOp,
    output logic       ALUSrc,
    output logic [1:0] GPRSel,
    output logic [1:0] WDSel,
    output logic [2:0] LAddr,
    output logic       instr_done,
    output logic       illegal,
    output logic [2:0] state
);

    state_t state_q, state_d;
    dec_t   dec;

    mc_decode u_decode (
        .op    (Op),
        .funct (Funct),
        .dec   (dec)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= state_t'(RESET_STATE);
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        MemWrite = MW_NONE;
        EXTOp    = 1'b0;
        ALUOp    = ALU_NOP;
        NPCOp    = NPC_PC4;
        ALUSrc   = 1'b0;
        GPRSel   = GPR_RD;
        WDSel    = WD_ALU;
        LAddr    = LA_WORD;
        illegal  = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (en) begin
                    IRWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                ALUOp   = dec.alu_op;
                ALUSrc  = dec.alu_src;
                EXTOp   = dec.ext_op;
                state_d = S_FETCH;
                case (dec.cls)
                    C_RALU, C_IALU:  state_d = S_WB;
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_BEQ: begin
                        PCWrite = 1'b1;
                        NPCOp   = Zero ? NPC_BR : NPC_PC4;
                    end
                    C_BNE: begin
                        PCWrite = 1'b1;
                        NPCOp   = Zero ? NPC_PC4 : NPC_BR;
                    end
                    C_J: begin
                        PCWrite = 1'b1;
                        NPCOp   = NPC_J;
                    end
                    C_JAL: begin
                        PCWrite  = 1'b1;
                        NPCOp    = NPC_J;
                        RegWrite = 1'b1;
                        GPRSel   = dec.gpr_sel;
                        WDSel    = dec.wd_sel;
                    end
                    C_JR: begin
                        PCWrite = 1'b1;
                        NPCOp   = NPC_JR;
                    end
                    C_NOP: PCWrite = 1'b1;
                    default: begin
                        PCWrite = 1'b1;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                // ALU fields stay driven so the memory address is stable.
                ALUOp  = dec.alu_op;
                ALUSrc = dec.alu_src;
                EXTOp  = dec.ext_op;
                if (dec.cls == C_STORE) begin
                    MemWrite = dec.mem_write;
                    PCWrite  = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                ALUOp    = dec.alu_op;
                ALUSrc   = dec.alu_src;
                EXTOp    = dec.ext_op;
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                GPRSel   = dec.gpr_sel;
                WDSel    = dec.wd_sel;
                LAddr    = dec.laddr;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        instr_done = PCWrite;

        // Reset suppresses every write in the cycle it is seen.
        if (rst) begin
            state_d    = state_t'(RESET_STATE);
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = MW_NONE;
            EXTOp      = 1'b0;
            ALUOp      = ALU_NOP;
            NPCOp      = NPC_PC4;
            ALUSrc     = 1'b0;
            GPRSel     = GPR_RD;
            WDSel      = WD_ALU;
            LAddr      = LA_WORD;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign state = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle vector table plus instruction latency checks.
module tb_mc_ctrl;

    logic       clk, rst, en, Zero;
    logic [5:0] Op, Funct;
    logic       PCWrite, IRWrite, RegWrite, EXTOp, ALUSrc, instr_done, illegal;
    logic [1:0] MemWrite, NPCOp, GPRSel, WDSel;
    logic [3:0] ALUOp;
    logic [2:0] LAddr, state;

    int n_checks = 0;
    int n_fail   = 0;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp),
        .ALUSrc(ALUSrc), .GPRSel(GPRSel), .WDSel(WDSel), .LAddr(LAddr),
        .instr_done(instr_done), .illegal(illegal), .state(state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [5:0] LW = 6'b100011, LB = 6'b100000, SW = 6'b101011, SB = 6'b101000;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010, JAL = 6'b000011;
    localparam logic [5:0] RT = 6'b000000, ADDI = 6'b001000, ORI = 6'b001101, LUI = 6'b001111;
    localparam logic [5:0] F_ADD = 6'b100000, F_SLT = 6'b101010, F_JR = 6'b001000, F_NOP = 6'b000000;
    localparam logic [5:0] BAD = 6'b111111;

    typedef struct {
        logic        rst;
        logic        en;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [2:0]  exp_state;
        logic [21:0] exp_out;
    } vec_t;

    vec_t vecs[$];

    // {PCWrite,IRWrite,RegWrite,MemWrite,EXTOp,ALUOp,NPCOp,ALUSrc,GPRSel,WDSel,LAddr,instr_done,illegal}
    function automatic logic [21:0] o(logic pc, logic ir, logic rw, logic [1:0] mw, logic ext,
                                      logic [3:0] alu, logic [1:0] npc, logic src,
                                      logic [1:0] gpr, logic [1:0] wd, logic [2:0] la, logic ill);
        return {pc, ir, rw, mw, ext, alu, npc, src, gpr, wd, la, pc, ill};
    endfunction

    function automatic logic [21:0] actual_out();
        return {PCWrite, IRWrite, RegWrite, MemWrite, EXTOp, ALUOp, NPCOp, ALUSrc,
                GPRSel, WDSel, LAddr, instr_done, illegal};
    endfunction

    logic [21:0] z, ir_only;

    task automatic add(input logic r, input logic e, input logic [5:0] op, input logic [5:0] fn,
                       input logic zr, input logic [2:0] st, input logic [21:0] out);
        vec_t v;
        v.rst = r; v.en = e; v.op = op; v.funct = fn; v.zero = zr;
        v.exp_state = st; v.exp_out = out;
        vecs.push_back(v);
    endtask

    // FETCH, DECODE and EXEC rows of one instruction
    task automatic seq3(input logic [5:0] op, input logic [5:0] fn, input logic zr,
                        input logic [21:0] exec_out);
        add(0, 1, op, fn, zr, 3'd0, ir_only);
        add(0, 0, op, fn, zr, 3'd1, z);
        add(0, 0, op, fn, zr, 3'd2, exec_out);
    endtask

    // driver: one instruction from FETCH, counting cycles up to instr_done
    task automatic run_lat(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int exp_lat);
        int cycles;
        bit seen;
        seen = 0;
        @(negedge clk);
        rst = 0; en = 1; Op = op; Funct = fn; Zero = 0;
        cycles = 1;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (instr_done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            en = 0;
            cycles++;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL latency_%s: no instr_done within 10 cycles, required %0d", name, exp_lat);
        end else if (cycles != exp_lat) begin
            n_fail++;
            $display("FAIL latency_%s: got %0d cycles, required %0d", name, cycles, exp_lat);
        end
        @(negedge clk);
        en = 0;
    endtask

    initial begin
        z       = '0;
        ir_only = o(0,1,0,2'd0,0,4'd0,2'd0,0,2'd0,2'd0,3'd0,0);

        // reset held: outputs zero even with en=1
        add(1, 1, LW, 0, 0, 3'd0, z);
        add(1, 1, LW, 0, 0, 3'd0, z);
        // lw: full 5-state walk
        seq3(LW, 0, 0, o(0,0,0,2'd0,1,4'd1,2'd0,1,2'd0,2'd0,3'd0,0));
        add(0, 0, LW, 0, 0, 3'd3, o(0,0,0,2'd0,1,4'd1,2'd0,1,2'd0,2'd0,3'd0,0));
        add(0, 0, LW, 0, 0, 3'd4, o(1,0,1,2'd0,1,4'd1,2'd0,1,2'd1,2'd1,3'd0,0));
        // lb: WB selects signed byte load
        seq3(LB, 0, 0, o(0,0,0,2'd0,1,4'd1,2'd0,1,2'd0,2'd0,3'd0,0));
        add(0, 0, LB, 0, 0, 3'd3, o(0,0,0,2'd0,1,4'd1,2'd0,1,2'd0,2'd0,3'd0,0));
        add(0, 0, LB, 0, 0, 3'd4, o(1,0,1,2'd0,1,4'd1,2'd0,1,2'd1,2'd1,3'd1,0));
        // branches
        seq3(BEQ, 0, 1, o(1,0,0,2'd0,1,4'd2,2'd1,0,2'd0,2'd0,3'd0,0));
        seq3(BEQ, 0, 0, o(1,0,0,2'd0,1,4'd2,2'd0,0,2'd0,2'd0,3'd0,0));
        seq3(BNE, 0, 0, o(1,0,0,2'd0,1,4'd2,2'd1,0,2'd0,2'd0,3'd0,0));
        seq3(BNE, 0, 1, o(1,0,0,2'd0,1,4'd2,2'd0,0,2'd0,2'd0,3'd0,0));
        // jumps, jr, nop
        seq3(JAL, 0, 0, o(1,0,1,2'd0,0,4'd0,2'd2,0,2'd2,2'd2,3'd0,0));
        add(0, 0, JAL, 0, 0, 3'd0, z);
        seq3(J, 0, 0, o(1,0,0,2'd0,0,4'd0,2'd2,0,2'd0,2'd0,3'd0,0));
        seq3(RT, F_JR, 0, o(1,0,0,2'd0,0,4'd0,2'd3,0,2'd0,2'd0,3'd0,0));
        seq3(RT, F_NOP, 0, o(1,0,0,2'd0,0,4'd0,2'd0,0,2'd0,2'd0,3'd0,0));
        // sb: byte store in MEM, no WB
        seq3(SB, 0, 0, o(0,0,0,2'd0,1,4'd1,2'd0,1,2'd0,2'd0,3'd0,0));
        add(0, 0, SB, 0, 0, 3'd3, o(1,0,0,2'd2,1,4'd1,2'd0,1,2'd0,2'd0,3'd0,0));
        add(0, 0, SB, 0, 0, 3'd0, z);
        // illegal opcode, then add completes normally
        seq3(BAD, 0, 0, o(1,0,0,2'd0,0,4'd0,2'd0,0,2'd0,2'd0,3'd0,1));
        seq3(RT, F_ADD, 0, o(0,0,0,2'd0,0,4'd1,2'd0,0,2'd0,2'd0,3'd0,0));
        add(0, 0, RT, F_ADD, 0, 3'd4, o(1,0,1,2'd0,0,4'd1,2'd0,0,2'd0,2'd0,3'd0,0));
        // illegal R-type funct
        seq3(RT, BAD, 0, o(1,0,0,2'd0,0,4'd0,2'd0,0,2'd0,2'd0,3'd0,1));
        // I-ALU and slt
        seq3(ORI, 0, 0, o(0,0,0,2'd0,0,4'd4,2'd0,1,2'd0,2'd0,3'd0,0));
        add(0, 0, ORI, 0, 0, 3'd4, o(1,0,1,2'd0,0,4'd4,2'd0,1,2'd1,2'd0,3'd0,0));
        seq3(ADDI, 0, 0, o(0,0,0,2'd0,1,4'd1,2'd0,1,2'd0,2'd0,3'd0,0));
        add(0, 0, ADDI, 0, 0, 3'd4, o(1,0,1,2'd0,1,4'd1,2'd0,1,2'd1,2'd0,3'd0,0));
        seq3(LUI, 0, 0, o(0,0,0,2'd0,0,4'd6,2'd0,1,2'd0,2'd0,3'd0,0));
        add(0, 0, LUI, 0, 0, 3'd4, o(1,0,1,2'd0,0,4'd6,2'd0,1,2'd1,2'd0,3'd0,0));
        seq3(RT, F_SLT, 0, o(0,0,0,2'd0,0,4'd5,2'd0,0,2'd0,2'd0,3'd0,0));
        add(0, 0, RT, F_SLT, 0, 3'd4, o(1,0,1,2'd0,0,4'd5,2'd0,0,2'd0,2'd0,3'd0,0));
        // rst during sw MEM: no write, back to FETCH, en=0 idles
        seq3(SW, 0, 0, o(0,0,0,2'd0,1,4'd1,2'd0,1,2'd0,2'd0,3'd0,0));
        add(1, 0, SW, 0, 0, 3'd0, z);
        for (int i = 0; i < 5; i++) add(0, 0, SW, 0, 0, 3'd0, z);
        seq3(RT, F_NOP, 0, o(1,0,0,2'd0,0,4'd0,2'd0,0,2'd0,2'd0,3'd0,0));
        add(0, 0, RT, F_NOP, 0, 3'd0, z);

        rst = 1; en = 0; Op = '0; Funct = '0; Zero = 0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; en = vecs[i].en; Op = vecs[i].op;
            Funct = vecs[i].funct; Zero = vecs[i].zero;
            #1;
            n_checks++;
            if (state !== vecs[i].exp_state) begin
                n_fail++;
                $display("FAIL row%0d_state: got %0d, required %0d", i, state, vecs[i].exp_state);
            end
            n_checks++;
            if (actual_out() !== vecs[i].exp_out) begin
                n_fail++;
                $display("FAIL row%0d_outputs: got %b, required %b", i, actual_out(), vecs[i].exp_out);
            end
        end

        run_lat("j",    J,    0,     3);
        run_lat("jal",  JAL,  0,     3);
        run_lat("jr",   RT,   F_JR,  3);
        run_lat("beq",  BEQ,  0,     3);
        run_lat("bne",  BNE,  0,     3);
        run_lat("nop",  RT,   F_NOP, 3);
        run_lat("bad",  BAD,  0,     3);
        run_lat("add",  RT,   F_ADD, 4);
        run_lat("addi", ADDI, 0,     4);
        run_lat("sw",   SW,   0,     4);
        run_lat("sb",   SB,   0,     4);
        run_lat("lw",   LW,   0,     5);
        run_lat("lb",   LB,   0,     5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle sequencer for the MIPS datapath. It replaces the single-cycle combinational control with a state machine that splits each instruction into FETCH/DECODE/EXEC/MEM/WB. It generates the same control-signal set the datapath already uses (RegWrite, MemWrite, EXTOp, ALUOp, NPCOp, ALUSrc, GPRSel, WDSel, LAddr), plus PCWrite and IRWrite. An en input lets the debug front-end single-step instructions.

Parameters:
RESET_STATE, 3'd0 (FETCH), state entered on reset.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  allow a new instruction to begin (sampled in FETCH).
Op  in  6  opcode, from the latched instruction register.
Funct  in  6  funct field, from the latched instruction register.
Zero  in  1  ALU zero flag, combinational.
PCWrite  out  1  PC load enable.
IRWrite  out  1  instruction register load enable.
RegWrite  out  1  register file write enable.
MemWrite  out  2  00 none, 01 word, 10 byte.
EXTOp  out  1  1 sign-extend, 0 zero-extend.
ALUOp  out  4  ALU operation code.
NPCOp  out  2  00 PC+4, 01 branch, 10 jump, 11 jr.
ALUSrc  out  1  ALU B source: 1 Imm32, 0 rt data.
GPRSel  out  2  write address: 00 rd, 01 rt, 10 $31.
WDSel  out  2  write data: 00 aluout, 01 readdata, 10 PC+4.
LAddr  out  3  load width: 000 word, 001 signed byte.
instr_done  out  1  one-cycle pulse in the final state of each instruction.
illegal  out  1  one-cycle pulse when an unsupported instruction completes.
state  out  3  current state, for debug.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high. On rst: state <= FETCH. While rst=1, every output is forced to 0.
- Control outputs are combinational from state, Op, Funct and Zero. Only the state register is sequential.
- PC update rule: PC is written exactly once per instruction, in that instruction's final state. PC is held constant for the rest of the instruction, so PC+4 (jal link, NPC) refers to the current instruction.
- FETCH:
  - en=1: IRWrite=1, next state DECODE.
  - en=0: stay in FETCH, all outputs 0.
- DECODE: no enables asserted; next state EXEC.
- EXEC: ALUOp, ALUSrc and EXTOp are driven per instruction class. Final state for:
  - beq/bne: PCWrite=1; NPCOp=01 if the branch is taken (beq: Zero=1; bne: Zero=0), else 00.
  - j: PCWrite=1, NPCOp=10.
  - jal: PCWrite=1, NPCOp=10, RegWrite=1, GPRSel=10, WDSel=10.
  - jr (R-type, funct 001000): PCWrite=1, NPCOp=11.
  - nop (R-type, funct 000000): PCWrite=1, NPCOp=00.
  - unsupported: PCWrite=1, NPCOp=00, illegal=1.
  - Next state: R-ALU, I-ALU -> WB; loads, stores -> MEM; final-state classes -> FETCH.
- MEM:
  - lw/lb: ALU outputs held, next state WB.
  - sw: MemWrite=01. sb: MemWrite=10. PCWrite=1, next state FETCH.
- WB: RegWrite=1, PCWrite=1, NPCOp=00; next state FETCH.
  - R-ALU: GPRSel=00, WDSel=00.
  - I-ALU: GPRSel=01, WDSel=00.
  - Loads: GPRSel=01, WDSel=01; LAddr=000 for lw, 001 for lb. ALU outputs held so the address stays stable.
- instr_done=1 in every cycle that asserts PCWrite.
- Unused state encodings (5-7) go to FETCH with all outputs 0.
- Instruction latencies: j, jal, jr, beq, bne, nop and unsupported take 3 cycles; R-ALU, I-ALU and stores take 4; loads take 5.
- Supported instructions:
  - R-type funct: add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - I-type: addi 001000 (sign-extend), ori 001101 (zero-extend), lui 001111 (ALUOp LUI).
  - Loads/stores: lw 100011, lb 100000, sw 101011, sb 101000. Address = ADD, sign-extend, ALUSrc=1.
  - Branches: beq 000100, bne 000101. ALUOp SUB, ALUSrc=0, EXTOp=1.
  - Jumps: j 000010, jal 000011.
- ALUOp codes: NOP 0, ADD 1, SUB 2, AND 3, OR 4, SLT 5, LUI 6.
- rst mid-instruction: the next state is FETCH and no PC, register or memory write occurs in the reset cycle.

Decomposition:
- Shared package mc_pkg holds:
  - opcode and funct constants;
  - ALUOp, NPCOp, WDSel, GPRSel, MemWrite and LAddr encodings;
  - state encoding: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4.
- One combinational sub-module, mc_decode, maps Op/Funct to an instruction class plus the static fields (ALUOp, EXTOp, ALUSrc, GPRSel, WDSel, LAddr).
- mc_ctrl contains the state register and the per-state gating of enables.

Test Plan:
- lw (Op 100011), en=1: state sequence 0,1,2,3,4,0. IRWrite only in cycle 1. In WB: RegWrite=1, WDSel=01, GPRSel=01, LAddr=000, PCWrite=1, instr_done=1.
- beq with Zero=1 in EXEC: PCWrite=1, NPCOp=01, 3-cycle instruction. Repeat with Zero=0: NPCOp=00.
- jal (Op 000011): EXEC asserts RegWrite=1, GPRSel=10, WDSel=10, NPCOp=10, PCWrite=1; next state FETCH.
- sb (Op 101000): MEM asserts MemWrite=10, RegWrite=0; no WB state.
- Illegal Op 111111: EXEC asserts illegal=1, PCWrite=1, NPCOp=00, no RegWrite or MemWrite; a following add completes normally.
- rst=1 while in MEM of sw: MemWrite=0 in that cycle, state=0 next cycle. With en=0, state stays 0 and IRWrite=0 for 5 cycles; en=1 then fetches.
